// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC result buffer.
// DATA_W is the MAC accumulator width carried through the buffer.
package mac_pkg;
  localparam int DATA_W         = 20;
  localparam int DEFAULT_DROP_W = 8;

  typedef struct packed {
    logic              wrap;
    logic [DATA_W-1:0] data;
  } result_entry_t;
endpackage

// File: rtl/result_fifo_mem.sv
// DEPTH x result_entry_t storage: one synchronous write port, one async read port.
// No reset on the array; validity is tracked by the pointer/count logic in the parent.
module result_fifo_mem
  import mac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [PTR_W-1:0]   i_wr_addr,
  input  result_entry_t      i_wr_dat,
  input  logic [PTR_W-1:0]   i_rd_addr,
  output result_entry_t      o_rd_dat
);
  result_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_addr];
endmodule

// File: rtl/mac_result_buffer.sv
// FIFO buffering MAC results with a saturating drop counter; 1-cycle push-to-output latency.
// Wrap flag per entry when MAC_WRAP_DETECT_EN is defined; otherwise out_wrap is 0.
module mac_result_buffer
  import mac_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = DEFAULT_DROP_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          f_in,
  input  logic                       valid_in,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_wrap,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic [DROP_W-1:0]          drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DROP_W-1:0] r_drop_cnt;

  logic          w_full;
  logic          w_not_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_wrap;
  result_entry_t w_wr_entry;
  result_entry_t w_head;

  assign w_full      = (r_count == FULL_CNT);
  assign w_not_empty = (r_count != '0);
  assign w_pop       = w_not_empty & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push      = valid_in & (~w_full | w_pop);
  assign w_drop      = valid_in & w_full & ~w_pop;

`ifdef MAC_WRAP_DETECT_EN
  logic [DATA_W-1:0] r_prev_f;

  // Tracks every offered result, dropped ones included, so wrap reflects the MAC stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_prev_f <= '0;
    else if (valid_in) r_prev_f <= f_in;
  end

  assign w_wrap = (f_in < r_prev_f);
`else
  assign w_wrap = 1'b0;
`endif

  assign w_wr_entry = '{wrap: w_wrap, data: f_in};

  result_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  (w_wr_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Masking keeps outputs at zero while empty, since the array itself is never cleared.
  assign out_valid = w_not_empty;
  assign out_data  = w_not_empty ? w_head.data : '0;
  assign out_wrap  = w_not_empty & w_head.wrap;
  assign count     = r_count;
  assign full      = w_full;
  assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_mac_result_buffer.sv
// Scoreboard bench for mac_result_buffer: in-order delivery, drops, saturation, wrap, reset.
module tb_mac_result_buffer;
  localparam int DEPTH    = 4;
  localparam int DROP_W   = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] f_in;
  logic        valid_in;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_wrap;
  logic [2:0]  count;
  logic        full;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [19:0] q_dat[$];
  logic        q_wrap[$];
  logic [19:0] m_prev;
  int          m_drop;

  mac_result_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_in      (f_in),
    .valid_in  (valid_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wrap  (out_wrap),
    .count     (count),
    .full      (full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    q_dat.delete();
    q_wrap.delete();
    m_prev = '0;
    m_drop = 0;
  endtask

  // Called #1 after a rising edge; drives one cycle, updates the scoreboard and checks.
  task automatic cycle(input logic vin, input logic [19:0] d, input logic rdy);
    int   sz;
    logic m_full, pop, push, drop, w;
    valid_in  = vin;
    f_in      = d;
    out_ready = rdy;
    sz = q_dat.size();
    checks++;
    if (out_valid !== (sz != 0)) begin
      errors++;
      $display("FAIL out_valid got %0b exp %0b", out_valid, (sz != 0));
    end
    if (sz != 0) begin
      checks++;
      if (out_data !== q_dat[0] || out_wrap !== q_wrap[0]) begin
        errors++;
        $display("FAIL head got %05h/%0b exp %05h/%0b", out_data, out_wrap, q_dat[0], q_wrap[0]);
      end
    end
    m_full = (sz == DEPTH);
    pop    = (sz != 0) && rdy;
    push   = vin && (!m_full || pop);
    drop   = vin && m_full && !pop;
`ifdef MAC_WRAP_DETECT_EN
    w = (d < m_prev);
    if (vin) m_prev = d;
`else
    w = 1'b0;
`endif
    if (pop) begin
      q_dat.delete(0);
      q_wrap.delete(0);
    end
    if (push) begin
      q_dat.push_back(d);
      q_wrap.push_back(w);
    end
    if (drop && m_drop < DROP_MAX) m_drop++;
    @(posedge clk);
    #1;
    checks++;
    if (count !== 3'(q_dat.size()) || full !== (q_dat.size() == DEPTH) || drop_cnt !== 8'(m_drop)) begin
      errors++;
      $display("FAIL state got cnt=%0d full=%0b drop=%0d exp cnt=%0d full=%0b drop=%0d",
               count, full, drop_cnt, q_dat.size(), (q_dat.size() == DEPTH), m_drop);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    valid_in = 1'b0; f_in = '0; out_ready = 1'b0;
    reset = 1'b0;
    model_clear();
    #3;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0 || drop_cnt !== 8'd0 ||
        out_data !== 20'd0 || out_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got vld=%0b cnt=%0d full=%0b drop=%0d dat=%05h wrap=%0b exp all zero",
               out_valid, count, full, drop_cnt, out_data, out_wrap);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_in_order();
    logic [19:0] vals [3] = '{20'd1, 20'd5, 20'd14};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, vals[i], 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || count > 3'd1) begin
        errors++;
        $display("FAIL in_order got vld=%0b dat=%0d cnt=%0d exp vld=1 dat=%0d cnt<=1",
                 out_valid, out_data, count, vals[i]);
      end
      cycle(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_fill_drop();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 20'(10 + i), 1'b0);
      if (i == 3) begin
        checks++;
        if (full !== 1'b1) begin
          errors++;
          $display("FAIL full_after_4 got %0b exp 1", full);
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL drop_two got %0d exp 2", drop_cnt);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_full_push_pop();
    logic [7:0] d0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 20'(32 + i), 1'b0);
    d0 = drop_cnt;
    cycle(1'b1, 20'h00040, 1'b1);
    checks++;
    if (count !== 3'd4 || drop_cnt !== d0) begin
      errors++;
      $display("FAIL full_push_pop got cnt=%0d drop=%0d exp cnt=4 drop=%0d", count, drop_cnt, d0);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), 20'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    logic exp2;
`ifdef MAC_WRAP_DETECT_EN
    exp2 = 1'b1;
`else
    exp2 = 1'b0;
`endif
    apply_reset();
    cycle(1'b1, 20'hFFFF0, 1'b0);
    checks++;
    if (out_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_first got %0b exp 0", out_wrap);
    end
    cycle(1'b1, 20'h00010, 1'b1);
    checks++;
    if (out_data !== 20'h00010 || out_wrap !== exp2) begin
      errors++;
      $display("FAIL wrap_second got %05h/%0b exp 00010/%0b", out_data, out_wrap, exp2);
    end
    cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b1, 20'(100 + i), 1'b0);
    valid_in = 1'b0;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got vld=%0b cnt=%0d exp vld=0 cnt=0", out_valid, count);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b1, 20'h00007, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 20'h00007 || count !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_push got vld=%0b dat=%05h cnt=%0d exp 1/00007/1", out_valid, out_data, count);
    end
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_alone got vld=%0b exp 0", out_valid);
    end
  endtask

  task automatic test_drop_sat();
    apply_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 20'(200 + i), 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 20'(i), 1'b0);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_sat got %0d exp 255", drop_cnt);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_fill_drop();
    test_full_push_pop();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_drop_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_result_buffer.md
MAC_RESULT_BUFFER -- requirements
Module: mac_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter DROP_W, default 8, width of drop counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port f_in  input  20  accumulator result from upstream MAC stage.
REQ-006 SHALL have port valid_in  input  1  f_in valid this cycle (upstream valid_out).
REQ-007 SHALL have port out_data  output  20  head-of-FIFO result.
REQ-008 SHALL have port out_valid  output  1  out_data valid (FIFO not empty).
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-010 SHALL have port out_wrap  output  1  head entry's wrap flag (macro-dependent, REQ-028).
REQ-011 SHALL have port count  output  $clog2(DEPTH+1)  entries held.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port drop_cnt  output  DROP_W  results lost while full.

Function
REQ-014 Push SHALL occur when valid_in=1 and (full=0 or pop occurs same cycle).
REQ-015 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-016 Pushed entry SHALL appear at out_data/out_valid the cycle after the push edge when FIFO was empty (1-cycle latency).
REQ-017 out_data, out_wrap SHALL be driven from registered storage; no combinational path f_in->out_data.
REQ-018 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when full or when count=1.
REQ-020 Pop when empty SHALL be ignored; count never underflows.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH.
REQ-022 valid_in=1 while full and no pop SHALL drop f_in and increment drop_cnt by 1.
REQ-023 drop_cnt SHALL saturate at 2^DROP_W-1; never wrap.
REQ-024 Results SHALL exit in arrival order, bit-exact, no arithmetic on data.

Reset
REQ-025 reset=0 SHALL immediately clear pointers, count, drop_cnt, prev register; out_valid=0, full=0, out_data=0, out_wrap=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored entries; first push after deassertion behaves as into empty FIFO.

Configuration
REQ-027 Macro MAC_WRAP_DETECT_EN SHALL control wrap detection.
REQ-028 With MAC_WRAP_DETECT_EN defined: register prev_f (reset 0) updated on every valid_in (including dropped); stored wrap bit = (f_in < prev_f); out_wrap = head entry's bit.
REQ-029 Without MAC_WRAP_DETECT_EN: no prev_f register, no wrap storage, out_wrap tied 0; all other behaviour identical.

Structure
REQ-030 Shared package mac_pkg SHALL hold DATA_W=20, default DROP_W, and typedef struct result_entry_t {wrap, data[DATA_W-1:0]}.
REQ-031 Storage SHALL be sub-module result_fifo_mem (DEPTH x result_entry_t, 1 write port, 1 async-read port); pointer/count/drop logic in top.

Verification
REQ-032 Reset then valid_in pulses f_in=1,5,14 with out_ready=1 -> out_data 1,5,14 each one cycle after push, count never >1.
REQ-033 out_ready=0, push 6 values 10..15, DEPTH=4 -> full=1 after 4th, drop_cnt=2, then drain yields 10,11,12,13.
REQ-034 Full FIFO, valid_in=1 and out_ready=1 same cycle -> push accepted, count stays 4, drop_cnt unchanged.
REQ-035 MAC_WRAP_DETECT_EN defined, pushes 0xFFFF0 then 0x00010 -> out_wrap 0 then 1; undefined -> out_wrap 0 both.
REQ-036 Push 3 entries, assert reset for 1 cycle mid-stream -> out_valid=0, count=0 asynchronously; next push 0x00007 emerges alone.
REQ-037 Hold full, 300 dropped pushes, DROP_W=8 -> drop_cnt=255.
